// File: rtl/rx_timer_pkg.sv
// rx_timer_pkg: shared constants for the USB full-speed receive bit timer.
//   BIT_LEN_BASE / BIT_LEN_REM : integer and remainder parts of the default 25/3 clocks per bit.
//   PERIOD_DEN_DEF             : default denominator of the clocks-per-bit ratio.
//   SAMPLE_OFFSET_DEF          : default tick within a bit at which the sample strobe fires.
//   BIT_COUNT_W                : width of the per-byte bit counter.
package rx_timer_pkg;

    localparam int unsigned PERIOD_DEN_DEF    = 3;
    localparam int unsigned BIT_LEN_BASE      = 8;  // 25 / 3
    localparam int unsigned BIT_LEN_REM       = 1;  // 25 % 3
    localparam int unsigned SAMPLE_OFFSET_DEF = 4;
    localparam int unsigned BIT_COUNT_W       = 4;

endpackage

// File: rtl/rx_bit_counter.sv
// rx_bit_counter: counts sampled data bits into bytes, skipping stuff bits.
// Ports:
//   clk, rst       : clock and asynchronous active-high reset.
//   clear          : synchronous clear of the bit count and byte pulse.
//   strobe         : one-cycle sample pulse from the bit timer.
//   stuffed_bit    : the bit sampled on this strobe is a stuff bit.
//   bit_count      : data bits received in the current byte.
//   byte_received  : one-cycle pulse the cycle after the last bit of a byte.
module rx_bit_counter
    import rx_timer_pkg::*;
#(
    parameter int unsigned BITS_PER_BYTE = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   strobe,
    input  logic                   stuffed_bit,
    output logic [BIT_COUNT_W-1:0] bit_count,
    output logic                   byte_received
);

    logic [BIT_COUNT_W-1:0] bit_count_q, bit_count_d;
    logic                   byte_q, byte_d;

    always_comb begin
        bit_count_d = bit_count_q;
        byte_d      = 1'b0;
        if (clear) begin
            bit_count_d = '0;
        end else if (strobe && !stuffed_bit) begin
            if (bit_count_q == BIT_COUNT_W'(BITS_PER_BYTE - 1)) begin
                bit_count_d = '0;
                byte_d      = 1'b1;
            end else begin
                bit_count_d = bit_count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_count_q <= '0;
            byte_q      <= 1'b0;
        end else begin
            bit_count_q <= bit_count_d;
            byte_q      <= byte_d;
        end
    end

    assign bit_count     = bit_count_q;
    assign byte_received = byte_q;

endmodule

// File: rtl/rx_timer.sv
// rx_timer: receive-side bit timer for the USB full-speed link.
// Recovers bit timing from line transitions at PERIOD_NUM/PERIOD_DEN clocks per bit, issues a
// one-cycle sample strobe SAMPLE_OFFSET ticks into each bit and counts data bits into bytes.
// Optional build macro RX_TIMER_STUFF_WATCHDOG_EN adds a watchdog that flags seven sampled bits
// without a transition; without it stuff_err is tied low.
// Ports:
//   clk, rst       : clock and asynchronous active-high reset.
//   enable_timer   : packet reception active; timing and counts hold while low.
//   clear_timer    : synchronous clear of all timing and bit state (wins over everything).
//   edge_detect    : one-cycle pulse on a line transition; resynchronises the tick counter.
//   stuffed_bit    : bit sampled on this strobe is a stuff bit.
//   shift_strobe   : one-cycle sample/shift pulse.
//   bit_count      : data bits received in the current byte.
//   byte_received  : one-cycle pulse after the last bit of a byte.
//   stuff_err      : watchdog error pulse.
module rx_timer
    import rx_timer_pkg::*;
#(
    parameter int unsigned PERIOD_NUM    = BIT_LEN_BASE * PERIOD_DEN_DEF + BIT_LEN_REM,
    parameter int unsigned PERIOD_DEN    = PERIOD_DEN_DEF,
    parameter int unsigned SAMPLE_OFFSET = SAMPLE_OFFSET_DEF,
    parameter int unsigned BITS_PER_BYTE = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable_timer,
    input  logic                   clear_timer,
    input  logic                   edge_detect,
    input  logic                   stuffed_bit,
    output logic                   shift_strobe,
    output logic [BIT_COUNT_W-1:0] bit_count,
    output logic                   byte_received,
    output logic                   stuff_err
);

    localparam int unsigned LEN_BASE = PERIOD_NUM / PERIOD_DEN;
    localparam int unsigned LEN_REM  = PERIOD_NUM % PERIOD_DEN;
    localparam int unsigned CNT_W    = $clog2(LEN_BASE + 2);
    localparam int unsigned ACC_W    = (PERIOD_DEN > 2) ? $clog2(PERIOD_DEN) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W:0]   acc_sum;
    logic             long_bit;
    logic             last_tick;

    // Bresenham fraction: a bit is one clock longer whenever the accumulated remainder overflows.
    always_comb begin
        acc_sum   = {1'b0, acc_q} + (ACC_W + 1)'(LEN_REM);
        long_bit  = acc_sum >= (ACC_W + 1)'(PERIOD_DEN);
        last_tick = cnt_q == (CNT_W'(LEN_BASE - 1) + CNT_W'(long_bit));
    end

    always_comb begin
        cnt_d = cnt_q;
        acc_d = acc_q;
        if (clear_timer) begin
            cnt_d = '0;
            acc_d = '0;
        end else if (enable_timer) begin
            if (edge_detect) begin
                // The edge cycle is tick 0, so the register resumes at tick 1.
                cnt_d = CNT_W'(1);
            end else if (last_tick) begin
                cnt_d = '0;
                acc_d = long_bit ? ACC_W'(acc_sum - (ACC_W + 1)'(PERIOD_DEN)) : ACC_W'(acc_sum);
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            acc_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            acc_q <= acc_d;
        end
    end

    assign shift_strobe = enable_timer && (cnt_q == CNT_W'(SAMPLE_OFFSET)) && !clear_timer;

    rx_bit_counter #(
        .BITS_PER_BYTE (BITS_PER_BYTE)
    ) u_bit_counter (
        .clk           (clk),
        .rst           (rst),
        .clear         (clear_timer),
        .strobe        (shift_strobe),
        .stuffed_bit   (stuffed_bit),
        .bit_count     (bit_count),
        .byte_received (byte_received)
    );

`ifdef RX_TIMER_STUFF_WATCHDOG_EN
    logic [2:0] run_q, run_d;
    logic       err_q, err_d;

    // Run of strobes since the last transition; the seventh strobe in a run is an error.
    always_comb begin
        err_d = shift_strobe && (run_q == 3'd6);
        run_d = run_q;
        if (clear_timer) begin
            run_d = '0;
        end else if (err_d || (enable_timer && edge_detect)) begin
            run_d = '0;
        end else if (shift_strobe) begin
            run_d = run_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q <= '0;
            err_q <= 1'b0;
        end else begin
            run_q <= run_d;
            err_q <= err_d;
        end
    end

    assign stuff_err = err_q;
`else
    assign stuff_err = 1'b0;
`endif

endmodule

// File: tb/tb_rx_timer.sv
// tb_rx_timer: scoreboard bench for rx_timer. Stimulus pushes expected strobe, byte and error
// events (cycle relative to phase start); a negedge monitor pops and compares them.
module tb_rx_timer;

    logic       clk           = 1'b0;
    logic       rst           = 1'b1;
    logic       enable_timer  = 1'b0;
    logic       clear_timer   = 1'b0;
    logic       edge_detect   = 1'b0;
    logic       stuffed_bit   = 1'b0;
    logic       shift_strobe;
    logic [3:0] bit_count;
    logic       byte_received;
    logic       stuff_err;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int t0          = 0;

    typedef struct {
        int cyc;
        int bc;
    } strobe_exp_t;

    strobe_exp_t strobe_q[$];
    int          byte_q[$];
    int          err_q[$];
    strobe_exp_t mon_e;
    int          mon_c;

    rx_timer dut (
        .clk           (clk),
        .rst           (rst),
        .enable_timer  (enable_timer),
        .clear_timer   (clear_timer),
        .edge_detect   (edge_detect),
        .stuffed_bit   (stuffed_bit),
        .shift_strobe  (shift_strobe),
        .bit_count     (bit_count),
        .byte_received (byte_received),
        .stuff_err     (stuff_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (phase cycle %0d)", name, actual, expected,
                     cyc - t0);
        end
    endtask

    task automatic push_strobe(input int c, input int bc);
        strobe_exp_t e;
        e.cyc = c;
        e.bc  = bc;
        strobe_q.push_back(e);
    endtask

    // Monitor: every output event must match the head of its expectation queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (shift_strobe) begin
                if (strobe_q.size() == 0) begin
                    check("unexpected_strobe", cyc - t0, -1);
                end else begin
                    mon_e = strobe_q.pop_front();
                    check("strobe_cycle", cyc - t0, mon_e.cyc);
                    check("strobe_bit_count", int'(bit_count), mon_e.bc);
                end
            end
            if (byte_received) begin
                if (byte_q.size() == 0) begin
                    check("unexpected_byte_received", cyc - t0, -1);
                end else begin
                    mon_c = byte_q.pop_front();
                    check("byte_received_cycle", cyc - t0, mon_c);
                end
            end
            if (stuff_err) begin
                if (err_q.size() == 0) begin
                    check("unexpected_stuff_err", cyc - t0, -1);
                end else begin
                    mon_c = err_q.pop_front();
                    check("stuff_err_cycle", cyc - t0, mon_c);
                end
            end
        end
    end

    // Pulse clear for one cycle with enable high; tick 0 is the cycle after.
    task automatic start_phase();
        clear_timer  = 1'b1;
        enable_timer = 1'b1;
        edge_detect  = 1'b0;
        stuffed_bit  = 1'b0;
        @(posedge clk);
        #1;
        clear_timer = 1'b0;
        t0          = cyc;
    endtask

    // Drive n cycles; single-cycle events at the given phase cycles (-1 = none),
    // enable low for cycles off_lo..off_hi.
    task automatic run(input int n, input int edge_at, input int stuff_at, input int clear_at,
                       input int off_lo, input int off_hi);
        for (int k = 0; k < n; k++) begin
            edge_detect  = (k == edge_at);
            stuffed_bit  = (k == stuff_at);
            clear_timer  = (k == clear_at);
            enable_timer = !(k >= off_lo && k <= off_hi);
            @(posedge clk);
            #1;
        end
        edge_detect  = 1'b0;
        stuffed_bit  = 1'b0;
        clear_timer  = 1'b0;
        enable_timer = 1'b1;
    endtask

    initial begin
        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("reset_shift_strobe", int'(shift_strobe), 0);
        check("reset_bit_count", int'(bit_count), 0);
        check("reset_byte_received", int'(byte_received), 0);
        check("reset_stuff_err", int'(stuff_err), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // A: free-running, bit lengths 8,8,9,8.
        push_strobe(4, 0);
        push_strobe(12, 1);
        push_strobe(20, 2);
        push_strobe(29, 3);
        start_phase();
        run(30, -1, -1, -1, -1, -2);
        check("free_run_bit_count", int'(bit_count), 4);

        // B: edge at tick 2 of the second bit resyncs; fraction phase continues.
        push_strobe(4, 0);
        push_strobe(14, 1);
        push_strobe(22, 2);
        push_strobe(31, 3);
        start_phase();
        run(32, 10, -1, -1, -1, -2);

        // C: eight data bits make a byte; seven edge-free strobes trip the watchdog.
        push_strobe(4, 0);
        push_strobe(12, 1);
        push_strobe(20, 2);
        push_strobe(29, 3);
        push_strobe(37, 4);
        push_strobe(45, 5);
        push_strobe(54, 6);
        push_strobe(62, 7);
        byte_q.push_back(63);
`ifdef RX_TIMER_STUFF_WATCHDOG_EN
        err_q.push_back(55);
`endif
        start_phase();
        run(66, -1, -1, -1, -1, -2);
        check("byte_wrap_bit_count", int'(bit_count), 0);

        // D: fourth strobe is a stuff bit; edge after strobe six (tick 7 of a 9-clock bit).
        push_strobe(4, 0);
        push_strobe(12, 1);
        push_strobe(20, 2);
        push_strobe(29, 3);
        push_strobe(37, 3);
        push_strobe(45, 4);
        push_strobe(52, 5);
        push_strobe(61, 6);
        push_strobe(69, 7);
        byte_q.push_back(70);
        start_phase();
        run(72, 48, 29, -1, -1, -2);
        check("stuffed_byte_bit_count", int'(bit_count), 0);

        // E: clear on a strobe tick suppresses it; enable low 5 cycles delays the next strobe.
        push_strobe(4, 0);
        push_strobe(17, 0);
        push_strobe(30, 1);
        start_phase();
        run(32, -1, -1, 12, 23, 27);
        check("clear_enable_bit_count", int'(bit_count), 2);

        // F: asynchronous reset mid-byte, on a strobe tick.
        push_strobe(4, 0);
        push_strobe(12, 1);
        start_phase();
        run(20, -1, -1, -1, -1, -2);
        check("pre_reset_strobe", int'(shift_strobe), 1);
        check("pre_reset_bit_count", int'(bit_count), 2);
        rst = 1'b1;
        #1;
        check("async_reset_strobe", int'(shift_strobe), 0);
        check("async_reset_bit_count", int'(bit_count), 0);
        check("async_reset_byte_received", int'(byte_received), 0);
        check("async_reset_stuff_err", int'(stuff_err), 0);
        enable_timer = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        check("strobes_outstanding", strobe_q.size(), 0);
        check("bytes_outstanding", byte_q.size(), 0);
        check("errors_outstanding", err_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
